tx_feeder: RTL and testbench
============================

TX_FEEDER -- requirements
Module: tx_feeder

Interface
REQ-001 Parameter DEPTH, default 4: FIFO depth in words; power of two, 2..16.
REQ-002 Parameter TMO, default 15: max cycles spent in WAIT_BUSY before abandoning a word; range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 in_valid  input  1  producer offers in_data this cycle.
REQ-006 in_data  input  3  word to be transmitted.
REQ-007 in_ready  output  1  FIFO can accept a word; combinational, equals (level != DEPTH).
REQ-008 tx  output  1  registered one-cycle launch strobe to downstream transmit FSM.
REQ-009 data  output  3  registered word presented to the downstream FSM.
REQ-010 busy  input  1  downstream FSM is processing a word.
REQ-011 err  output  1  registered one-cycle pulse; a word was dropped on timeout.
REQ-012 level  output  clog2(DEPTH)+1  number of words currently held in the FIFO.

Function
REQ-013 Push when in_valid && in_ready at a rising edge; in_data is written at the tail; level increments.
REQ-014 in_valid while in_ready=0 is ignored; no overwrite, no level change.
REQ-015 Pointers wrap modulo DEPTH; no ordering loss across wrap.
REQ-016 Pop only on the IDLE->LAUNCH transition; head word is loaded into data on the same edge.
REQ-017 Same-edge push and pop: level unchanged, both operations take effect.
REQ-018 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if level>0 and busy=0, go to LAUNCH; otherwise stay in IDLE.
REQ-020 LAUNCH: tx=1 for exactly this one cycle; always go to WAIT_BUSY; busy is ignored in this cycle.
REQ-021 WAIT_BUSY: on entry clear the timeout counter to 0.
  - busy=1: go to WAIT_DONE.
  - busy=0 and counter==TMO-1: go to IDLE, assert err=1 in the following cycle, discard the word.
  - Otherwise: increment the counter and stay in WAIT_BUSY.
REQ-022 WAIT_DONE: if busy=0, go to IDLE; otherwise stay in WAIT_DONE.
REQ-023 data holds its value from LAUNCH until the next pop; it never changes in WAIT_BUSY or WAIT_DONE.
REQ-024 tx and err are 0 in every cycle not specified above.
REQ-025 Latency: a word pushed into an empty FIFO at edge k, with busy=0, produces tx=1 in the cycle following edge k+1.
REQ-026 Minimum launch spacing: back-to-back words need one busy pulse each, giving at least 4 cycles between tx strobes.

Reset
REQ-027 While reset=0:
  - state is IDLE; FIFO pointers, level and timeout counter are 0;
  - tx=0, err=0, data=3'b000;
  - in_ready=1.
REQ-028 Reset asserted mid-transfer (any state) discards all buffered words and any in-flight word; no tx or err is issued for them after release.
REQ-029 The first push is accepted on the first rising edge with reset=1.

Verification
REQ-030 Single word: push 3'b101 to empty FIFO with busy=0 -> tx=1 for one cycle, 2 cycles after push, with data=3'b101; busy high 3 cycles then low -> state returns to IDLE, level=0.
REQ-031 Fill and stall (DEPTH=4): hold busy=1, push 3'b001..3'b100 -> level=4, in_ready=0, 5th push 3'b111 ignored; release busy -> words launched in order 001,010,011,100; 111 never appears.
REQ-032 Timeout (TMO=15): push 3'b110 and keep busy=0 forever -> one tx strobe, err=1 for exactly one cycle 15 cycles after WAIT_BUSY entry, level=0, no relaunch.
REQ-033 Simultaneous push/pop: level=2, push 3'b011 on the IDLE->LAUNCH edge -> level stays 2, popped head appears on data, 3'b011 is launched third.
REQ-034 Wrap: stream 10 words 0..7,0,1 through DEPTH=4 with busy responding after 1 cycle -> all 10 launched in order, no err.
REQ-035 Reset mid-operation: reset=0 for 1 cycle while in WAIT_DONE with level=3 -> tx=0, err=0, level=0, data=3'b000 immediately; no further tx without new pushes.

Source files
------------

// File: rtl/tx_feeder.sv
// tx_feeder: small word FIFO that launches one word at a time into a
// downstream transmit FSM using a tx strobe and a busy handshake.
// A word that never gets a busy acknowledgement within TMO cycles is
// dropped, and err pulses for one cycle.
module tx_feeder #(
  parameter int DEPTH = 4,
  parameter int TMO   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [2:0]               in_data,
  output logic                     in_ready,
  output logic                     tx,
  output logic [2:0]               data,
  input  logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [7:0]  TMO_END = 8'(TMO - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                 state, nxt;
  logic [DEPTH-1:0][2:0]  mem;
  logic [AW-1:0]          wptr, rptr;
  logic [7:0]             cnt;
  logic                   push, pop, tmo_hit;

  assign in_ready = (level != FULL);
  assign push     = in_valid && in_ready;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic; pop and timeout are decided here so tx/err line up
  always_comb begin
    nxt     = state;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE: if (level != '0 && !busy) begin
        nxt = LAUNCH;
        pop = 1'b1;
      end
      LAUNCH: nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) nxt = WAIT_DONE;
        else if (cnt == TMO_END) begin
          nxt     = IDLE;
          tmo_hit = 1'b1;
        end
      end
      WAIT_DONE: if (!busy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy; push and pop may share an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // timeout counter: zeroed while launching so WAIT_BUSY starts from 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       cnt <= '0;
    else if (state == LAUNCH)                         cnt <= '0;
    else if (state == WAIT_BUSY && !busy && !tmo_hit) cnt <= cnt + 1'b1;
  end

  // registered strobes and the launched word; data only moves on a pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx   <= 1'b0;
      err  <= 1'b0;
      data <= '0;
    end else begin
      tx  <= pop;
      err <= tmo_hit;
      if (pop) data <= mem[rptr];
    end
  end

endmodule

// File: tb/tb_tx_feeder.sv
// Scoreboard bench for tx_feeder: accepted words are queued, every tx
// strobe pops the queue and compares the launched data.
module tb_tx_feeder;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic in_ready, tx, err, busy;
  logic [2:0] data;
  logic [$clog2(DEPTH):0] level;

  logic busy_man = 1'b0, busy_resp = 1'b0, resp_en = 1'b0;
  int resp_dly = 1, resp_hold = 1;
  assign busy = resp_en ? busy_resp : busy_man;

  int checks = 0, failures = 0, cyc = 0, tx_cnt = 0, err_cnt = 0;
  int last_tx_cyc = 0, last_err_cyc = 0, push_cyc = 0;
  logic [2:0] exp_q[$];

  tx_feeder #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .data(data), .busy(busy), .err(err),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycle counter: number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: each tx strobe must launch the oldest accepted word
  always @(negedge clk) begin
    if (tx) begin
      tx_cnt++;
      last_tx_cyc = cyc;
      if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_data", int'(data), int'(exp_q.pop_front()));
    end
    if (err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  // downstream model: raise busy resp_dly cycles after tx, hold resp_hold cycles
  initial forever begin
    @(negedge clk);
    if (resp_en && tx) begin
      repeat (resp_dly) @(negedge clk);
      busy_resp = 1'b1;
      repeat (resp_hold) @(negedge clk);
      busy_resp = 1'b0;
    end
  end

  task automatic push(input logic [2:0] d, input bit acc);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; push_cyc = cyc;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_rdy(input logic [2:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_rdy", int'(in_ready), 1);
    in_valid = 1'b1; in_data = d; exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int n = 0;
    while (tx_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk(tag, int'(tx_cnt >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, e0, n;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(tx), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset = 1'b1;

    // single word: latency 2, busy high 3 cycles
    resp_en = 1'b1; resp_dly = 1; resp_hold = 3;
    push(3'b101, 1'b1);
    wait_tx(1, 20, "t1_tx_seen");
    chk("t1_latency", last_tx_cyc - push_cyc, 2);
    repeat (8) @(negedge clk);
    chk("t1_level", int'(level), 0);
    chk("t1_txcnt", tx_cnt, 1);
    chk("t1_err", err_cnt, 0);

    // fill and stall with busy held high
    resp_en = 1'b0; busy_man = 1'b1; resp_hold = 2;
    for (int i = 1; i <= 4; i++) push(3'(i), 1'b1);
    chk("t2_level_full", int'(level), 4);
    chk("t2_in_ready", int'(in_ready), 0);
    push(3'b111, 1'b0);
    chk("t2_level_after_drop", int'(level), 4);
    chk("t2_data_hold", int'(data), 3'b101);
    @(negedge clk); resp_en = 1'b1;
    wait_tx(5, 150, "t2_drain");
    repeat (10) @(negedge clk);
    chk("t2_level_empty", int'(level), 0);
    chk("t2_txcnt", tx_cnt, 5);
    chk("t2_q_empty", exp_q.size(), 0);

    // simultaneous push and pop
    resp_en = 1'b0; busy_man = 1'b1;
    push(3'b010, 1'b1);
    push(3'b110, 1'b1);
    chk("t3_level_pre", int'(level), 2);
    @(negedge clk);
    resp_en = 1'b1; in_valid = 1'b1; in_data = 3'b011; exp_q.push_back(3'b011);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_level_same", int'(level), 2);
    chk("t3_tx", int'(tx), 1);
    chk("t3_data", int'(data), 3'b010);
    wait_tx(8, 150, "t3_drain");
    repeat (10) @(negedge clk);
    chk("t3_level_empty", int'(level), 0);

    // timeout: busy never answers
    resp_en = 1'b0; busy_man = 1'b0;
    t0 = tx_cnt; e0 = err_cnt;
    push(3'b110, 1'b1);
    n = 0;
    while (err_cnt == e0 && n < 60) begin @(negedge clk); n++; end
    chk("t4_err_seen", int'(err_cnt > e0), 1);
    chk("t4_err_delay", last_err_cyc - last_tx_cyc, TMO + 1);
    repeat (30) @(negedge clk);
    chk("t4_err_cnt", err_cnt - e0, 1);
    chk("t4_tx_cnt", tx_cnt - t0, 1);
    chk("t4_level", int'(level), 0);
    chk("t4_data_hold", int'(data), 3'b110);

    // wrap: 10 words through the FIFO
    resp_en = 1'b1; resp_dly = 1; resp_hold = 1;
    t0 = tx_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) push_rdy(3'(i % 8));
    wait_tx(t0 + 10, 400, "t5_drain");
    repeat (6) @(negedge clk);
    chk("t5_err", err_cnt - e0, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // reset while in WAIT_DONE with 3 words buffered
    resp_en = 1'b0; busy_man = 1'b0;
    push(3'b111, 1'b1);
    n = 0;
    while (!tx && n < 20) begin @(negedge clk); n++; end
    chk("t6_launch", int'(tx), 1);
    busy_man = 1'b1;
    push(3'b001, 1'b1);
    push(3'b010, 1'b1);
    push(3'b011, 1'b1);
    chk("t6_level_pre", int'(level), 3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_tx", int'(tx), 0);
    chk("t6_rst_err", int'(err), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1; busy_man = 1'b0;
    t0 = tx_cnt; e0 = err_cnt;
    repeat (30) @(negedge clk);
    chk("t6_no_tx", tx_cnt - t0, 0);
    chk("t6_no_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
